// File: rtl/rom_sprite_display_pkg.sv
// Shared definitions for the ROM sprite display path: scale encoding,
// replica-counter helpers and RGB channel slicing.
package rom_sprite_display_pkg;

   localparam int DEF_PIX_W = 12;
   localparam int DEF_CNT_W = 11;

   typedef enum logic [1:0] {
      SCALE_1X     = 2'd0,
      SCALE_2X     = 2'd1,
      SCALE_4X     = 2'd2,
      SCALE_4X_ALT = 2'd3
   } scale_e;

   // Shift amount applied to image coordinates; the spare code behaves as 4x.
   function automatic logic [1:0] scale_shift(input logic [1:0] scale);
      case (scale)
         SCALE_1X: return 2'd0;
         SCALE_2X: return 2'd1;
         default:  return 2'd2;
      endcase
   endfunction

   // Terminal value of a replica counter for a given shift (2^s - 1).
   function automatic logic [1:0] rep_max(input logic [1:0] shift);
      case (shift)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // LSB position of channel idx (0=r, 1=g, 2=b) in a packed {r,g,b} word.
   function automatic int unsigned chan_lsb(input int unsigned pix_w, input int unsigned idx);
      return (2 - idx) * (pix_w / 3);
   endfunction

endpackage

// File: rtl/rom_sprite_display_rom_addr_gen.sv
// Raster-to-ROM address generator. Decodes the visible window and the image
// rectangle, and walks the ROM with incremental column/line counters plus
// horizontal and vertical replica counters for integer scaling.
module rom_addr_gen
   import rom_sprite_display_pkg::*;
#(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 17,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  h_cnt,
   input  logic [CNT_W-1:0]  v_cnt,
   input  logic [CNT_W-1:0]  h_start,
   input  logic [CNT_W-1:0]  v_start,
   input  logic [CNT_W-1:0]  h_visible,
   input  logic [CNT_W-1:0]  v_visible,
   input  logic [CNT_W-1:0]  pos_x,
   input  logic [CNT_W-1:0]  pos_y,
   input  logic [1:0]        scale,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              in_img,
   output logic              vis
);

   localparam int EXT_W = CNT_W + 3;

   logic              frame_start, armed_e;
   logic [CNT_W-1:0]  pos_x_e, pos_y_e;
   logic [1:0]        shift_e, rmax;
   logic [EXT_W-1:0]  hx, vx, col, row, px, py, img_w_s, img_h_s;
   logic              h_vis, v_vis, vis_c, in_img_c, row_first;
   logic [ADDR_W-1:0] line_base_e, cur_addr;
   logic [1:0]        h_rep_cur;

   logic [CNT_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [1:0]        shift_q, shift_d;
   logic              armed_q, armed_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d, addr_q, addr_d;
   logic [1:0]        h_rep_q, h_rep_d, v_rep_q, v_rep_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              in_img_q, in_img_d, vis_q, vis_d;

   // Window and image-rectangle decode; frame-start cycle already sees new geometry.
   always_comb begin
      frame_start = (h_cnt == '0) && (v_cnt == '0);
      pos_x_e     = frame_start ? pos_x : pos_x_q;
      pos_y_e     = frame_start ? pos_y : pos_y_q;
      shift_e     = frame_start ? scale_shift(scale) : shift_q;
      armed_e     = frame_start || armed_q;
      rmax        = rep_max(shift_e);
      hx          = EXT_W'(h_cnt);
      vx          = EXT_W'(v_cnt);
      h_vis       = (hx >= EXT_W'(h_start)) && (hx < EXT_W'(h_start) + EXT_W'(h_visible));
      v_vis       = (vx >= EXT_W'(v_start)) && (vx < EXT_W'(v_start) + EXT_W'(v_visible));
      col         = hx - EXT_W'(h_start);
      row         = vx - EXT_W'(v_start);
      px          = EXT_W'(pos_x_e);
      py          = EXT_W'(pos_y_e);
      img_w_s     = EXT_W'(IMG_W) << shift_e;
      img_h_s     = EXT_W'(IMG_H) << shift_e;
      vis_c       = armed_e && h_vis && v_vis;
      in_img_c    = vis_c && (col >= px) && (col < px + img_w_s)
                          && (row >= py) && (row < py + img_h_s);
   end

   // Incremental address walk: reload from line_base on row entry, step on
   // horizontal replica wrap, advance line_base on vertical replica wrap.
   always_comb begin
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      shift_d     = shift_q;
      armed_d     = armed_q;
      line_base_d = line_base_q;
      addr_d      = addr_q;
      h_rep_d     = h_rep_q;
      v_rep_d     = v_rep_q;
      rom_addr_d  = rom_addr_q;
      in_img_d    = in_img_c;
      vis_d       = vis_c;

      line_base_e = frame_start ? '0 : line_base_q;
      row_first   = in_img_c && (!in_img_q || frame_start);
      cur_addr    = row_first ? line_base_e : addr_q;
      h_rep_cur   = row_first ? 2'd0 : h_rep_q;

      if (in_img_c) begin
         rom_addr_d = cur_addr;
         if (h_rep_cur == rmax) begin
            h_rep_d = 2'd0;
            addr_d  = cur_addr + ADDR_W'(1);
         end else begin
            h_rep_d = h_rep_cur + 2'd1;
            addr_d  = cur_addr;
         end
      end else if (in_img_q) begin
         // Falling edge of in_img: the previous cycle was the row's last image pixel.
         h_rep_d = 2'd0;
         if (v_rep_q == rmax) begin
            v_rep_d     = 2'd0;
            line_base_d = line_base_q + ADDR_W'(IMG_W);
         end else begin
            v_rep_d = v_rep_q + 2'd1;
         end
      end

      if (frame_start) begin
         pos_x_d     = pos_x;
         pos_y_d     = pos_y;
         shift_d     = scale_shift(scale);
         armed_d     = 1'b1;
         line_base_d = '0;
         v_rep_d     = 2'd0;
      end
   end

   // State register; reset also disarms output until the next frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         shift_q     <= '0;
         armed_q     <= 1'b0;
         line_base_q <= '0;
         addr_q      <= '0;
         h_rep_q     <= '0;
         v_rep_q     <= '0;
         rom_addr_q  <= '0;
         in_img_q    <= 1'b0;
         vis_q       <= 1'b0;
      end else begin
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         shift_q     <= shift_d;
         armed_q     <= armed_d;
         line_base_q <= line_base_d;
         addr_q      <= addr_d;
         h_rep_q     <= h_rep_d;
         v_rep_q     <= v_rep_d;
         rom_addr_q  <= rom_addr_d;
         in_img_q    <= in_img_d;
         vis_q       <= vis_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign in_img   = in_img_q;
   assign vis      = vis_q;

endmodule

// File: rtl/rom_sprite_display.sv
// ROM sprite display top: address generation, ROM-latency matching pipeline
// for the vis/in_img/key flags, and the registered colour select.
module rom_sprite_display
   import rom_sprite_display_pkg::*;
#(
   parameter int IMG_W   = 320,
   parameter int IMG_H   = 240,
   parameter int ADDR_W  = 17,
   parameter int PIX_W   = DEF_PIX_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int ROM_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CNT_W-1:0]   h_cnt,
   input  logic [CNT_W-1:0]   v_cnt,
   input  logic [CNT_W-1:0]   h_start,
   input  logic [CNT_W-1:0]   v_start,
   input  logic [CNT_W-1:0]   h_visible,
   input  logic [CNT_W-1:0]   v_visible,
   input  logic [CNT_W-1:0]   pos_x,
   input  logic [CNT_W-1:0]   pos_y,
   input  logic [1:0]         scale,
   input  logic               key_en,
   input  logic [PIX_W-1:0]   key_color,
   input  logic [PIX_W-1:0]   bg_color,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [PIX_W-1:0]   rom_data,
   output logic [PIX_W/3-1:0] o_r,
   output logic [PIX_W/3-1:0] o_g,
   output logic [PIX_W/3-1:0] o_b,
   output logic               o_de
);

   localparam int C = PIX_W / 3;

   logic               img_s1, vis_s1;
   logic [ROM_LAT-1:0] vis_pipe_q, vis_pipe_d, img_pipe_q, img_pipe_d, key_pipe_q, key_pipe_d;
   logic [PIX_W-1:0]   rgb_q, rgb_d;
   logic               de_q, de_d;
   logic               vis_a, img_a, key_a;

   rom_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .h_start   (h_start),
      .v_start   (v_start),
      .h_visible (h_visible),
      .v_visible (v_visible),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .scale     (scale),
      .rom_addr  (rom_addr),
      .in_img    (img_s1),
      .vis       (vis_s1)
   );

   // Flag delay line matching ROM latency, then colour select for the output stage.
   always_comb begin
      vis_pipe_d    = vis_pipe_q;
      img_pipe_d    = img_pipe_q;
      key_pipe_d    = key_pipe_q;
      vis_pipe_d[0] = vis_s1;
      img_pipe_d[0] = img_s1;
      key_pipe_d[0] = key_en;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
         vis_pipe_d[i] = vis_pipe_q[i-1];
         img_pipe_d[i] = img_pipe_q[i-1];
         key_pipe_d[i] = key_pipe_q[i-1];
      end

      vis_a = vis_pipe_q[ROM_LAT-1];
      img_a = img_pipe_q[ROM_LAT-1];
      key_a = key_pipe_q[ROM_LAT-1];

      rgb_d = '0;
      de_d  = vis_a;
      if (vis_a) begin
         if (!img_a || (key_a && (rom_data == key_color))) rgb_d = bg_color;
         else                                              rgb_d = rom_data;
      end
   end

   // Pipeline and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         vis_pipe_q <= '0;
         img_pipe_q <= '0;
         key_pipe_q <= '0;
         rgb_q      <= '0;
         de_q       <= 1'b0;
      end else begin
         vis_pipe_q <= vis_pipe_d;
         img_pipe_q <= img_pipe_d;
         key_pipe_q <= key_pipe_d;
         rgb_q      <= rgb_d;
         de_q       <= de_d;
      end
   end

   assign o_r  = rgb_q[chan_lsb(PIX_W, 0) +: C];
   assign o_g  = rgb_q[chan_lsb(PIX_W, 1) +: C];
   assign o_b  = rgb_q[chan_lsb(PIX_W, 2) +: C];
   assign o_de = de_q;

endmodule

// File: tb/tb_rom_sprite_display.sv
// Directed bench for rom_sprite_display on a reduced raster (80x48 total,
// 64x40 visible at (8,3)) with a 16x8 image. Two instances: ROM_LAT=1 and 3.
// Addresses and outputs are logged per counter cycle, then compared.
module tb_rom_sprite_display;

   localparam int HT   = 80;
   localparam int VT   = 48;
   localparam int MAXC = 40000;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] h_cnt, v_cnt, h_start, v_start, h_visible, v_visible, pos_x, pos_y;
   logic [1:0]  scale;
   logic        key_en;
   logic [11:0] key_color, bg_color;
   logic [6:0]  rom_addr_a, rom_addr_b;
   logic [11:0] rom_data_a, rom_data_b;
   logic [11:0] rom_b_pipe [0:2];
   logic [3:0]  o_r_a, o_g_a, o_b_a, o_r_b, o_g_b, o_b_b;
   logic        o_de_a, o_de_b;

   logic [6:0]  addr_a_log [0:MAXC-1];
   logic [6:0]  addr_b_log [0:MAXC-1];
   logic [11:0] rgb_a_log  [0:MAXC-1];
   logic [11:0] rgb_b_log  [0:MAXC-1];
   logic        de_a_log   [0:MAXC-1];
   logic        de_b_log   [0:MAXC-1];

   int cyc = 0;
   int rst_from = 0;
   int rst_to = 0;
   int n_cmp = 0;
   int n_err = 0;
   int fstart [0:8];

   always #5 clk = ~clk;

   rom_sprite_display #(
      .IMG_W(16), .IMG_H(8), .ADDR_W(7), .PIX_W(12), .CNT_W(11), .ROM_LAT(1)
   ) u_a (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .h_start(h_start), .v_start(v_start), .h_visible(h_visible), .v_visible(v_visible),
      .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .key_en(key_en),
      .key_color(key_color), .bg_color(bg_color), .rom_addr(rom_addr_a),
      .rom_data(rom_data_a), .o_r(o_r_a), .o_g(o_g_a), .o_b(o_b_a), .o_de(o_de_a)
   );

   rom_sprite_display #(
      .IMG_W(16), .IMG_H(8), .ADDR_W(7), .PIX_W(12), .CNT_W(11), .ROM_LAT(3)
   ) u_b (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .h_start(h_start), .v_start(v_start), .h_visible(h_visible), .v_visible(v_visible),
      .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .key_en(key_en),
      .key_color(key_color), .bg_color(bg_color), .rom_addr(rom_addr_b),
      .rom_data(rom_data_b), .o_r(o_r_b), .o_g(o_g_b), .o_b(o_b_b), .o_de(o_de_b)
   );

   // ROM contents: 0x800 | address, except cell 5 which holds the key colour 0x0F0.
   function automatic logic [11:0] rom_fn(input logic [6:0] a);
      if (a == 7'd5) return 12'h0F0;
      return 12'h800 | {5'd0, a};
   endfunction

   always @(posedge clk) begin
      rom_data_a    <= rom_fn(rom_addr_a);
      rom_b_pipe[0] <= rom_fn(rom_addr_b);
      rom_b_pipe[1] <= rom_b_pipe[0];
      rom_b_pipe[2] <= rom_b_pipe[1];
   end
   assign rom_data_b = rom_b_pipe[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One counter cycle: apply (h,v), clock, log address for this cycle and
   // outputs belonging to the cycle L clocks earlier.
   task automatic step(input int h, input int v);
      h_cnt = 11'(h);
      v_cnt = 11'(v);
      rst   = (cyc >= rst_from) && (cyc < rst_to);
      @(posedge clk);
      #1;
      addr_a_log[cyc] = rom_addr_a;
      addr_b_log[cyc] = rom_addr_b;
      if (cyc + 1 >= 3) begin
         rgb_a_log[cyc-2] = {o_r_a, o_g_a, o_b_a};
         de_a_log[cyc-2]  = o_de_a;
      end
      if (cyc + 1 >= 5) begin
         rgb_b_log[cyc-4] = {o_r_b, o_g_b, o_b_b};
         de_b_log[cyc-4]  = o_de_b;
      end
      cyc++;
   endtask

   task automatic run_lines(input int v0, input int v1);
      for (int v = v0; v < v1; v++)
         for (int h = 0; h < HT; h++)
            step(h, v);
   endtask

   function automatic int at(input int f, input int h, input int v);
      return fstart[f] + v * HT + h;
   endfunction

   task automatic exp_addr(input string tag, input int f, input int h, input int v, input int a);
      check_eq(tag, 32'(addr_a_log[at(f, h, v)]), 32'(a));
   endtask

   task automatic exp_a(input string tag, input int f, input int h, input int v,
                        input logic [11:0] rgb, input logic de);
      check_eq({tag, ".rgb"}, 32'(rgb_a_log[at(f, h, v)]), 32'(rgb));
      check_eq({tag, ".de"},  32'(de_a_log[at(f, h, v)]),  32'(de));
   endtask

   task automatic exp_b(input string tag, input int f, input int h, input int v,
                        input logic [11:0] rgb, input logic de);
      check_eq({tag, ".rgb"}, 32'(rgb_b_log[at(f, h, v)]), 32'(rgb));
      check_eq({tag, ".de"},  32'(de_b_log[at(f, h, v)]),  32'(de));
   endtask

   function automatic void set_geom(input int px, input int py, input int s);
      pos_x = 11'(px);
      pos_y = 11'(py);
      scale = 2'(s);
   endfunction

   initial begin
      int c0;
      rst       = 1'b1;
      h_cnt     = '0;
      v_cnt     = '0;
      h_start   = 11'd8;
      v_start   = 11'd3;
      h_visible = 11'd64;
      v_visible = 11'd40;
      key_en    = 1'b0;
      key_color = 12'h0F0;
      bg_color  = 12'hABC;
      set_geom(0, 0, 0);
      rst_from  = 0;
      rst_to    = 4;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) step(0, 0);
      check_eq("reset.addr", 32'(rom_addr_a), 32'd0);
      check_eq("reset.rgb",  32'({o_r_a, o_g_a, o_b_a}), 32'd0);
      check_eq("reset.de",   32'(o_de_a), 32'd0);

      // Frames 0..4: basic, keyed, 2x offset, clipped right, 4x.
      fstart[0] = cyc; run_lines(0, VT);
      key_en = 1'b1;
      fstart[1] = cyc; run_lines(0, VT);
      key_en = 1'b0; set_geom(10, 5, 1);
      fstart[2] = cyc; run_lines(0, VT);
      set_geom(56, 0, 0);
      fstart[3] = cyc; run_lines(0, VT);
      set_geom(0, 0, 2);
      fstart[4] = cyc; run_lines(0, VT);
      // Frame 5: scale code 3, geometry changed mid-frame at line 8.
      set_geom(0, 0, 3);
      fstart[5] = cyc; run_lines(0, 8);
      set_geom(20, 2, 0);
      run_lines(8, VT);
      fstart[6] = cyc; run_lines(0, VT);
      // Frame 7: two-clock reset mid-line at (30,6).
      fstart[7] = cyc;
      rst_from  = at(7, 30, 6);
      rst_to    = rst_from + 2;
      run_lines(0, VT);
      fstart[8] = cyc; run_lines(0, VT);
      for (int h = 0; h < 10; h++) step(h, 0);

      exp_addr("f0.first.addr", 0, 8, 3, 0);
      exp_a   ("f0.first",      0, 8, 3, 12'h800, 1'b1);
      exp_a   ("f0.pre",        0, 7, 3, 12'h000, 1'b0);
      exp_addr("f0.rowend.addr",0, 23, 3, 15);
      exp_a   ("f0.rowend",     0, 23, 3, 12'h80F, 1'b1);
      exp_a   ("f0.rightbg",    0, 24, 3, 12'hABC, 1'b1);
      exp_a   ("f0.hblank",     0, 72, 3, 12'h000, 1'b0);
      exp_a   ("f0.row1",       0, 8, 4, 12'h810, 1'b1);
      exp_addr("f0.last.addr",  0, 23, 10, 127);
      exp_a   ("f0.last",       0, 23, 10, 12'h87F, 1'b1);
      exp_a   ("f0.belowbg",    0, 8, 11, 12'hABC, 1'b1);
      exp_a   ("f0.px5.nokey",  0, 13, 3, 12'h0F0, 1'b1);
      exp_b   ("b.f0.first",    0, 8, 3, 12'h800, 1'b1);
      exp_b   ("b.f0.pre",      0, 7, 3, 12'h000, 1'b0);

      exp_a   ("f1.px5.key",    1, 13, 3, 12'hABC, 1'b1);
      exp_a   ("f1.px4",        1, 12, 3, 12'h804, 1'b1);
      exp_a   ("f1.px6",        1, 14, 3, 12'h806, 1'b1);

      exp_addr("f2.c0",         2, 18, 8, 0);
      exp_addr("f2.c1",         2, 19, 8, 0);
      exp_addr("f2.c2",         2, 20, 8, 1);
      exp_addr("f2.row51",      2, 18, 9, 0);
      exp_addr("f2.row52",      2, 18, 10, 16);
      exp_addr("f2.last.addr",  2, 49, 23, 127);
      exp_a   ("f2.last",       2, 49, 23, 12'h87F, 1'b1);
      exp_a   ("f2.after",      2, 50, 23, 12'hABC, 1'b1);
      exp_a   ("f2.left",       2, 17, 8, 12'hABC, 1'b1);

      exp_addr("f3.clip",       3, 71, 3, 7);
      exp_addr("f3.row1",       3, 64, 4, 16);
      exp_addr("f3.row7",       3, 64, 10, 112);
      exp_a   ("f3.row7end",    3, 71, 10, 12'h877, 1'b1);

      exp_addr("f4.c3",         4, 11, 3, 0);
      exp_addr("f4.c4",         4, 12, 3, 1);
      exp_addr("f4.r3",         4, 8, 6, 0);
      exp_addr("f4.r4",         4, 8, 7, 16);
      exp_addr("f4.last",       4, 71, 34, 127);

      exp_addr("f5.s3.c4",      5, 12, 3, 1);
      exp_addr("f5.mid.addr",   5, 12, 20, 65);
      exp_a   ("f5.mid",        5, 12, 20, 12'h841, 1'b1);
      exp_addr("f5.last",       5, 71, 34, 127);

      exp_a   ("f6.top",        6, 28, 3, 12'hABC, 1'b1);
      exp_a   ("f6.leftbg",     6, 27, 5, 12'hABC, 1'b1);
      exp_addr("f6.first.addr", 6, 28, 5, 0);
      exp_a   ("f6.first",      6, 28, 5, 12'h800, 1'b1);
      exp_addr("f6.last",       6, 43, 12, 127);

      c0 = at(7, 30, 6);
      check_eq("rst.addr_a", 32'(addr_a_log[c0]), 32'd0);
      check_eq("rst.addr_b", 32'(addr_b_log[c0]), 32'd0);
      check_eq("rst.rgb_a",  32'(rgb_a_log[c0-2]), 32'd0);
      check_eq("rst.de_a",   32'(de_a_log[c0-2]),  32'd0);
      check_eq("rst.rgb_a2", 32'(rgb_a_log[c0-1]), 32'd0);
      check_eq("rst.rgb_b",  32'(rgb_b_log[c0-4]), 32'd0);
      check_eq("rst.de_b",   32'(de_b_log[c0-4]),  32'd0);

      exp_addr("f8.first.addr", 8, 28, 5, 0);
      exp_a   ("f8.first",      8, 28, 5, 12'h800, 1'b1);
      exp_b   ("b.f8.first",    8, 28, 5, 12'h800, 1'b1);
      exp_b   ("b.f8.leftbg",   8, 27, 5, 12'hABC, 1'b1);
      exp_addr("f8.last",       8, 43, 12, 127);
      exp_b   ("b.f8.last",     8, 43, 12, 12'h87F, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
